// File: rtl/imm_ext_pipe.sv
// Immediate extension stage with valid/ready handshake on both sides.
// Define IMM_EXT_SKID_EN to get a 2-entry skid buffer with a registered in_ready.
module imm_ext_pipe #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg
);

    typedef enum logic [1:0] {
        MODE_SEXT   = 2'b00,
        MODE_ZEXT   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_e;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    logic             in_fire;

    always_comb begin
        sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
        ext  = sext;
        case (mode_e'(in_mode))
            MODE_SEXT:   ext = sext;
            MODE_ZEXT:   ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
            MODE_UPPER:  ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
            MODE_BRANCH: ext = sext << 2;
            default:     ext = sext;
        endcase
    end

    assign in_fire = in_valid && in_ready;

`ifdef IMM_EXT_SKID_EN
    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;
    logic             skid_neg;

    // in_ready is just the skid-empty flag, held low while reset is asserted.
    assign in_ready = reset_n && !skid_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_neg    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_neg   <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // Skid entry is always older than anything on the input.
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_neg    <= skid_neg;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_fire;
                if (in_fire) begin
                    out_data <= ext;
                    out_neg  <= in_imm[IN_W-1];
                end
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= ext;
            skid_neg   <= in_imm[IN_W-1];
        end
    end
`else
    assign in_ready = reset_n && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_neg   <= 1'b0;
        end else if (!out_valid || out_ready) begin
            out_valid <= in_fire;
            if (in_fire) begin
                out_data <= ext;
                out_neg  <= in_imm[IN_W-1];
            end
        end
    end
`endif

endmodule
